reg_file_2r1w: RTL and testbench

Parametrised register file with one write port, two independent read ports, per-byte write enables and write-to-read bypass. A built-in clear sequencer zeroes the whole array on request without a reset. It is the general storage block for datapath register banks and configuration tables. It replaces single-port, mutually exclusive read/write register files.

---
 rtl/reg_file_2r1w.sv | 143 ++++++++++++++
 tb/tb_reg_file_2r1w.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with byte enables, write bypass and clear sequencer.
// Define RF_PARITY_EN to add per-entry even parity, parity injection and read parity-error flags.
module reg_file_2r1w #(
    parameter int RF_WIDTH   = 16,
    parameter int RF_DEPTH   = 8,
    parameter int ADDR_WIDTH = 3,
    localparam int BE_WIDTH  = RF_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic [RF_WIDTH-1:0]   wr_data,
    input  logic                  rd0_en,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic [RF_WIDTH-1:0]   rd0_data,
    output logic                  rd0_valid,
    input  logic                  rd1_en,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [RF_WIDTH-1:0]   rd1_data,
    output logic                  rd1_valid,
    input  logic                  clr_req,
`ifdef RF_PARITY_EN
    input  logic                  par_inj,
    output logic                  rd0_perr,
    output logic                  rd1_perr,
`endif
    output logic                  clr_busy,
    output logic                  clr_done
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [RF_WIDTH-1:0]   mem_q [RF_DEPTH];
    logic [RF_WIDTH-1:0]   mem_d [RF_DEPTH];
    logic [RF_WIDTH-1:0]   wr_old, wr_merged;
    logic [RF_WIDTH-1:0]   rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
    logic                  rd0_valid_q, rd1_valid_q;
    logic                  clearing, wr_acc, rd0_in, rd1_in;

    assign clearing = state_q == CLEAR;
    assign wr_acc   = wr_en && state_q == IDLE && 32'(wr_addr) < RF_DEPTH;
    assign rd0_in   = 32'(rd0_addr) < RF_DEPTH;
    assign rd1_in   = 32'(rd1_addr) < RF_DEPTH;
    assign wr_old   = wr_acc ? mem_q[wr_addr] : '0;

    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < BE_WIDTH; b++)
            wr_merged[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : wr_old[8*b +: 8];
    end

    // mem_d is the array as it will be after this edge, so reads of it give the bypass for free
    always_comb begin
        mem_d = mem_q;
        if (clearing)
            mem_d[cnt_q] = '0;
        else if (wr_acc)
            mem_d[wr_addr] = wr_merged;
    end

    assign rd0_data_d = rd0_en ? (rd0_in ? mem_d[rd0_addr] : '0) : rd0_data_q;
    assign rd1_data_d = rd1_en ? (rd1_in ? mem_d[rd1_addr] : '0) : rd1_data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = 32'(cnt_q) == RF_DEPTH - 1 ? DONE : CLEAR;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_q       <= '{default: '0};
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
            rd0_data_q  <= rd0_data_d;
            rd1_data_q  <= rd1_data_d;
            rd0_valid_q <= rd0_en;
            rd1_valid_q <= rd1_en;
        end
    end

    assign rd0_data  = rd0_data_q;
    assign rd1_data  = rd1_data_q;
    assign rd0_valid = rd0_valid_q;
    assign rd1_valid = rd1_valid_q;
    assign clr_busy  = state_q == CLEAR;
    assign clr_done  = state_q == DONE;

`ifdef RF_PARITY_EN
    logic par_q [RF_DEPTH];
    logic par_d [RF_DEPTH];
    logic rd0_perr_q, rd0_perr_d, rd1_perr_q, rd1_perr_d;

    always_comb begin
        par_d = par_q;
        if (clearing)
            par_d[cnt_q] = 1'b0;
        else if (wr_acc)
            par_d[wr_addr] = ^wr_merged ^ par_inj;
    end

    assign rd0_perr_d = rd0_en ? (rd0_in ? ^mem_d[rd0_addr] ^ par_d[rd0_addr] : 1'b0) : rd0_perr_q;
    assign rd1_perr_d = rd1_en ? (rd1_in ? ^mem_d[rd1_addr] ^ par_d[rd1_addr] : 1'b0) : rd1_perr_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_q      <= '{default: 1'b0};
            rd0_perr_q <= 1'b0;
            rd1_perr_q <= 1'b0;
        end else begin
            par_q      <= par_d;
            rd0_perr_q <= rd0_perr_d;
            rd1_perr_q <= rd1_perr_d;
        end
    end

    assign rd0_perr = rd0_perr_q;
    assign rd1_perr = rd1_perr_q;
`endif
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: randomized and directed checks of reg_file_2r1w against a cycle-level reference model.
module tb_reg_file_2r1w;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int BW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [BW-1:0] wr_be = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd0_en = 1'b0, rd1_en = 1'b0;
    logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
    logic [W-1:0]  rd0_data, rd1_data;
    logic          rd0_valid, rd1_valid;
    logic          clr_req = 1'b0;
    logic          clr_busy, clr_done;
`ifdef RF_PARITY_EN
    logic          par_inj = 1'b0;
    logic          rd0_perr, rd1_perr;
    logic          ref_bad [D];
    logic          exp_p0 = 1'b0, exp_p1 = 1'b0;
`endif

    int            n_chk = 0;
    int            n_fail = 0;
    logic [W-1:0]  ref_mem [D];
    int            clr_pos = -1;
    logic [W-1:0]  exp_d0 = '0, exp_d1 = '0;

    reg_file_2r1w #(.RF_WIDTH(W), .RF_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .clr_req(clr_req),
`ifdef RF_PARITY_EN
        .par_inj(par_inj), .rd0_perr(rd0_perr), .rd1_perr(rd1_perr),
`endif
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0; clr_req = 1'b0;
`ifdef RF_PARITY_EN
        par_inj = 1'b0;
`endif
    endtask

    // Advance the model over one edge using the currently driven inputs, then compare after the edge
    task automatic step();
        logic [W-1:0] v;
        if (clr_pos == -1 && wr_en && int'(wr_addr) < D) begin
            v = ref_mem[wr_addr];
            for (int b = 0; b < BW; b++)
                if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
            ref_mem[wr_addr] = v;
`ifdef RF_PARITY_EN
            ref_bad[wr_addr] = par_inj;
`endif
        end
        if (clr_pos >= 0 && clr_pos < D) begin
            ref_mem[clr_pos] = '0;
`ifdef RF_PARITY_EN
            ref_bad[clr_pos] = 1'b0;
`endif
        end
        if (rd0_en) exp_d0 = int'(rd0_addr) < D ? ref_mem[rd0_addr] : '0;
        if (rd1_en) exp_d1 = int'(rd1_addr) < D ? ref_mem[rd1_addr] : '0;
`ifdef RF_PARITY_EN
        if (rd0_en) exp_p0 = int'(rd0_addr) < D ? ref_bad[rd0_addr] : 1'b0;
        if (rd1_en) exp_p1 = int'(rd1_addr) < D ? ref_bad[rd1_addr] : 1'b0;
`endif
        clr_pos = clr_pos == -1 ? (clr_req ? 0 : -1) : (clr_pos == D ? -1 : clr_pos + 1);
        @(posedge CLK);
        #1;
        chk("rd0_valid", rd0_valid, rd0_en);
        chk("rd1_valid", rd1_valid, rd1_en);
        chk("rd0_data", rd0_data, exp_d0);
        chk("rd1_data", rd1_data, exp_d1);
        chk("clr_busy", clr_busy, clr_pos >= 0 && clr_pos < D);
        chk("clr_done", clr_done, clr_pos == D);
`ifdef RF_PARITY_EN
        chk("rd0_perr", rd0_perr, exp_p0);
        chk("rd1_perr", rd1_perr, exp_p1);
`endif
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        clr_pos = -1;
        exp_d0 = '0;
        exp_d1 = '0;
        chk("rst_rd0_data", rd0_data, 0);
        chk("rst_rd1_data", rd1_data, 0);
        chk("rst_rd0_valid", rd0_valid, 0);
        chk("rst_rd1_valid", rd1_valid, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
`ifdef RF_PARITY_EN
        for (int i = 0; i < D; i++) ref_bad[i] = 1'b0;
        exp_p0 = 1'b0;
        exp_p1 = 1'b0;
        chk("rst_rd0_perr", rd0_perr, 0);
        chk("rst_rd1_perr", rd1_perr, 0);
`endif
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [BW-1:0] be);
        idle_all();
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
        step();
    endtask

    task automatic rd0(input int a);
        idle_all();
        rd0_en = 1'b1; rd0_addr = AW'(a);
        step();
    endtask

    initial begin
        int busy_n;
        idle_all();
        do_reset();

        for (int a = 0; a < D; a++) begin
            idle_all();
            rd0_en = 1'b1; rd0_addr = AW'(a);
            rd1_en = 1'b1; rd1_addr = AW'(D - 1 - a);
            step();
            chk("init_zero", rd0_data, 0);
        end

        wr(2, 16'hA5C3, 2'b11);
        wr(2, 16'hFF11, 2'b01);
        wr(2, 16'h9999, 2'b00);
        rd0(2);
        chk("byte_merge", rd0_data, 16'hA511);

        idle_all();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234; wr_be = 2'b11;
        rd0_en = 1'b1; rd0_addr = 3'd5; rd1_en = 1'b1; rd1_addr = 3'd5;
        step();
        chk("bypass_rd0", rd0_data, 16'h1234);
        chk("bypass_rd1", rd1_data, 16'h1234);

        for (int a = 0; a < D; a++) wr(a, 16'hBEEF, 2'b11);
        idle_all();
        clr_req = 1'b1;
        step();
        busy_n = int'(clr_busy);
        for (int i = 0; i < 20 && !clr_done; i++) begin
            idle_all();
            if (i == 0) begin
                wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1111; wr_be = 2'b11;
            end
            rd0_en = 1'b1; rd0_addr = AW'(i % D);
            step();
            busy_n += int'(clr_busy);
        end
        chk("busy_len", busy_n, 8);
        chk("done_seen", clr_done, 1);
        for (int a = 0; a < D; a++) begin
            rd0(a);
            chk("cleared", rd0_data, 0);
        end

        wr(6, 16'hBEEF, 2'b11);
        idle_all();
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h7777; wr_be = 2'b11;
        step();
        for (int i = 0; i < 3; i++) begin
            idle_all();
            rd0_en = 1'b1; rd0_addr = 3'd6;
            step();
        end
        chk("pre_rst_rd0", rd0_data, 16'hBEEF);
        idle_all();
        do_reset();
        wr(4, 16'h5555, 2'b11);
        rd0(4);
        chk("post_rst_wr", rd0_data, 16'h5555);

`ifdef RF_PARITY_EN
        idle_all();
        par_inj = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0001; wr_be = 2'b11;
        step();
        rd0(1);
        chk("perr_inj", rd0_perr, 1);
        wr(1, 16'h0001, 2'b11);
        rd0(1);
        chk("perr_clean", rd0_perr, 0);
`endif

        for (int i = 0; i < 400; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, D - 1));
            wr_be    = BW'($urandom);
            wr_data  = W'($urandom);
            rd0_en   = 1'($urandom_range(0, 1));
            rd0_addr = $urandom_range(0, 3) == 0 ? wr_addr : AW'($urandom_range(0, D - 1));
            rd1_en   = 1'($urandom_range(0, 1));
            rd1_addr = $urandom_range(0, 3) == 0 ? wr_addr : AW'($urandom_range(0, D - 1));
            clr_req  = $urandom_range(0, 24) == 0;
`ifdef RF_PARITY_EN
            par_inj  = $urandom_range(0, 5) == 0;
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
